// File: rtl/sub3_arith_if.sv
// Operand/result bundle for the arithmetic slot: operands and op code in, result and flag out.
interface sub3_arith_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             in_valid;
    logic [WIDTH-1:0] z;
    logic             out_valid;
    logic             flag;

    modport master (
        output a, b, op, in_valid,
        input  z, out_valid, flag
    );

    modport slave (
        input  a, b, op, in_valid,
        output z, out_valid, flag
    );
endinterface

// File: rtl/sub3_arith.sv
// Two-stage registered arithmetic: wrap add, wrap subtract, saturating add, low-half multiply.
// Stage 1 captures the raw wide result; stage 2 truncates it and derives the carry/borrow/overflow flag.
module sub3_arith #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    sub3_arith_if.slave  bus
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_SAT = 2'b10,
        OP_MUL = 2'b11
    } op_e;

    localparam int RAW_W = 2 * WIDTH;

    if (LATENCY != 2) begin : g_bad_latency
        $error("sub3_arith supports only LATENCY == 2");
    end

    // Saturating add: bit WIDTH carries the saturation indication, low bits the clamped sum.
    function automatic logic [WIDTH:0] sat_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s[WIDTH]) begin
            sat_add = {1'b1, {WIDTH{1'b1}}};
        end else begin
            sat_add = s;
        end
    endfunction

    function automatic logic flag_of(input op_e o, input logic [RAW_W-1:0] raw);
        if (o == OP_MUL) begin
            flag_of = |raw[RAW_W-1:WIDTH];
        end else begin
            flag_of = raw[WIDTH];
        end
    endfunction

    logic [WIDTH:0]   sum_c;
    logic [WIDTH:0]   diff_c;
    logic [RAW_W-1:0] prod_c;
    logic [RAW_W-1:0] raw_c;

    op_e              op_p1;
    logic [RAW_W-1:0] raw_p1;
    logic             vld_p1;

    logic [WIDTH-1:0] z_p2;
    logic             flag_p2;
    logic             vld_p2;

    assign sum_c  = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff_c = {1'b0, bus.a} - {1'b0, bus.b};
    assign prod_c = RAW_W'(bus.a) * RAW_W'(bus.b);

    always_comb begin
        raw_c = '0;
        unique case (op_e'(bus.op))
            OP_ADD:  raw_c = {{(RAW_W-WIDTH-1){1'b0}}, sum_c};
            OP_SUB:  raw_c = {{(RAW_W-WIDTH-1){1'b0}}, diff_c};
            OP_SAT:  raw_c = {{(RAW_W-WIDTH-1){1'b0}}, sat_add(bus.a, bus.b)};
            OP_MUL:  raw_c = prod_c;
            default: raw_c = '0;
        endcase
    end

    // Stage 1: capture op and raw result; data holds when no operand is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_p1  <= OP_ADD;
            raw_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= bus.in_valid;
            if (bus.in_valid) begin
                op_p1  <= op_e'(bus.op);
                raw_p1 <= raw_c;
            end
        end
    end

    // Stage 2: truncate to WIDTH and derive the flag; z holds its last result between ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_p2    <= '0;
            flag_p2 <= 1'b0;
            vld_p2  <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                z_p2    <= raw_p1[WIDTH-1:0];
                flag_p2 <= flag_of(op_p1, raw_p1);
            end
        end
    end

    assign bus.z         = z_p2;
    assign bus.flag      = flag_p2;
    assign bus.out_valid = vld_p2;

endmodule

// File: tb/tb_sub3_arith.sv
// Directed bench for sub3_arith: reset, each op code, wrap/borrow/saturation edges, streaming, reset mid-flight.
module tb_sub3_arith;

    localparam int WIDTH = 16;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    sub3_arith_if #(.WIDTH(WIDTH)) bus ();

    sub3_arith #(.WIDTH(WIDTH), .LATENCY(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.a        = 'x;
        bus.b        = 'x;
        bus.op       = 'x;
    endtask

    // Issue one op, then check the 2-edge latency, the one-cycle valid pulse and the held result.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] ez, input logic ef);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        step();
        idle();
        chk({tag, "_vld_early"}, 32'(bus.out_valid), 32'd0);
        step();
        chk({tag, "_vld"},  32'(bus.out_valid), 32'd1);
        chk({tag, "_z"},    32'(bus.z),         32'(ez));
        chk({tag, "_flag"}, 32'(bus.flag),      32'(ef));
        step();
        chk({tag, "_vld_drop"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_z_hold"},   32'(bus.z),         32'(ez));
    endtask

    logic [1:0]  s_op [4];
    logic [15:0] s_a  [4];
    logic [15:0] s_b  [4];
    logic [15:0] s_z  [4];
    logic        s_f  [4];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        idle();

        // Reset with clock running.
        repeat (3) step();
        chk("rst_z",    32'(bus.z),         32'd0);
        chk("rst_vld",  32'(bus.out_valid), 32'd0);
        chk("rst_flag", 32'(bus.flag),      32'd0);
        rst_n = 1'b1;
        repeat (3) step();
        chk("rel_z",    32'(bus.z),         32'd0);
        chk("rel_vld",  32'(bus.out_valid), 32'd0);
        chk("rel_flag", 32'(bus.flag),      32'd0);

        do_op("add1",   2'b00, 16'd2000,  16'd1000,  16'd3000,  1'b0);
        do_op("add2",   2'b00, 16'd5000,  16'd3000,  16'd8000,  1'b0);
        do_op("addwrp", 2'b00, 16'hFFFF,  16'd2,     16'h0001,  1'b1);
        do_op("subbrw", 2'b01, 16'd1000,  16'd2000,  16'hFC18,  1'b1);
        do_op("subok",  2'b01, 16'd2000,  16'd1000,  16'd1000,  1'b0);
        do_op("satsat", 2'b10, 16'hF000,  16'h2000,  16'hFFFF,  1'b1);
        do_op("satok",  2'b10, 16'h1000,  16'h2000,  16'h3000,  1'b0);
        do_op("mulovf", 2'b11, 16'd300,   16'd300,   16'h5F90,  1'b1);
        do_op("mulok",  2'b11, 16'd3,     16'd4,     16'd12,    1'b0);

        // Streaming: four mixed ops on consecutive cycles.
        s_op[0] = 2'b00; s_a[0] = 16'd10;    s_b[0] = 16'd20;    s_z[0] = 16'd30;    s_f[0] = 1'b0;
        s_op[1] = 2'b01; s_a[1] = 16'd5;     s_b[1] = 16'd7;     s_z[1] = 16'hFFFE;  s_f[1] = 1'b1;
        s_op[2] = 2'b10; s_a[2] = 16'hFFFF;  s_b[2] = 16'd1;     s_z[2] = 16'hFFFF;  s_f[2] = 1'b1;
        s_op[3] = 2'b11; s_a[3] = 16'h0100;  s_b[3] = 16'h0100;  s_z[3] = 16'h0000;  s_f[3] = 1'b1;
        for (int j = 0; j < 6; j++) begin
            if (j < 4) begin
                bus.in_valid = 1'b1;
                bus.op       = s_op[j];
                bus.a        = s_a[j];
                bus.b        = s_b[j];
            end else begin
                idle();
            end
            step();
            if (j >= 1 && j <= 4) begin
                chk($sformatf("strm%0d_vld", j-1),  32'(bus.out_valid), 32'd1);
                chk($sformatf("strm%0d_z", j-1),    32'(bus.z),         32'(s_z[j-1]));
                chk($sformatf("strm%0d_flag", j-1), 32'(bus.flag),      32'(s_f[j-1]));
            end else if (j == 5) begin
                chk("strm_end_vld", 32'(bus.out_valid), 32'd0);
            end
        end

        // Reset while an op sits in stage 1: it must never emerge.
        bus.in_valid = 1'b1;
        bus.op       = 2'b00;
        bus.a        = 16'd1;
        bus.b        = 16'd1;
        step();
        idle();
        rst_n = 1'b0;
        #1;
        chk("mid1_vld", 32'(bus.out_valid), 32'd0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("mid1_ghost%0d", k), 32'(bus.out_valid), 32'd0);
        end
        chk("mid1_z", 32'(bus.z), 32'd0);

        // Reset while out_valid is high drops it in the same cycle.
        bus.in_valid = 1'b1;
        bus.op       = 2'b00;
        bus.a        = 16'd7;
        bus.b        = 16'd8;
        step();
        idle();
        step();
        chk("mid2_vld_pre", 32'(bus.out_valid), 32'd1);
        chk("mid2_z_pre",   32'(bus.z),         32'd15);
        rst_n = 1'b0;
        #1;
        chk("mid2_vld", 32'(bus.out_valid), 32'd0);
        chk("mid2_z",   32'(bus.z),         32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("mid2_ghost", 32'(bus.out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
